wb_rob_writer: RTL and testbench
================================

// Module: wb_rob_writer
// PURPOSE
//  Writeback stage directly downstream of the M/WB pipeline register.
//  - Accepts one completed memory-stage result per cycle (load data, exception info, ROB id).
//  - Buffers accepted results in a small in-order FIFO.
//  - Drains the FIFO through the single ROB completion write port.
//  - Backpressures M/WB with a registered stall when the FIFO is full.
//  - Drops all buffered results on a ROB flush.
// PARAMETERS
//  WORD_SIZE        `WORD_SIZE        data/address width
//  INSTR_TYPE_SZ    `INSTR_TYPE_SZ    instruction type field width
//  ROB_ENTRY_WIDTH  `ROB_ENTRY_WIDTH  ROB index width
//  FIFO_DEPTH       2                 buffer entries; power of 2, >=2
// PORTS
//  clk                   in   1                clock, rising edge
//  reset                 in   1                asynchronous, active-low reset
//  flush                 in   1                ROB flush; discard all buffered and incoming results
//  valid_in              in   1                M/WB valid_out
//  instruction_type_in   in   INSTR_TYPE_SZ    M/WB instruction_type_out
//  pc_in                 in   WORD_SIZE        M/WB pc_out
//  exception_in          in   1                M/WB exception_out
//  vaddr_exception_in    in   WORD_SIZE        M/WB virtual_addr_exception_out
//  load_data_in          in   WORD_SIZE        M/WB load_data_out
//  rob_id_in             in   ROB_ENTRY_WIDTH  M/WB rob_id_out
//  stall_out             out  1                to M/WB stall; registered, 1 = FIFO full
//  rob_wr_ready          in   1                ROB write port free this cycle
//  rob_wr_valid          out  1                head entry valid
//  rob_wr_id             out  ROB_ENTRY_WIDTH  head rob_id
//  rob_wr_type           out  INSTR_TYPE_SZ    head instruction_type
//  rob_wr_pc             out  WORD_SIZE        head pc
//  rob_wr_exception      out  1                head exception
//  rob_wr_vaddr          out  WORD_SIZE        head virtual_addr_exception
//  rob_wr_data           out  WORD_SIZE        head load_data
// BEHAVIOUR
//  Reset (reset==0, asynchronous):
//   - wr_ptr, rd_ptr, count = 0; stall_out = 0; rob_wr_valid = 0.
//   - All rob_wr_* data outputs read 0 (storage cleared).
//  Push: valid_in && !stall_out && !flush at a clk edge; entry written at wr_ptr, wr_ptr++.
//  Pop: rob_wr_valid && rob_wr_ready && !flush at a clk edge; rd_ptr++.
//  Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
//  Simultaneous push and pop: count unchanged; both pointers advance.
//  Latency: an entry pushed at edge N is visible on rob_wr_* in the cycle after edge N.
//   No combinational input->output bypass.
//  rob_wr_valid = (count != 0). rob_wr_* show the rd_ptr entry, which is held stable while not popped.
//  stall_out is a flop set to (next_count == FIFO_DEPTH).
//   - No combinational path from rob_wr_ready to stall_out.
//   - When full, a pop that cycle still leaves stall_out = 1 for that cycle.
//   - M/WB holds its payload while stalled, so no input is lost.
//  Input while stall_out = 1 is ignored; M/WB holds it.
//  Flush at an edge:
//   - count, wr_ptr, rd_ptr = 0; stall_out = 0; the same-cycle input is dropped.
//   - rob_wr_valid = 0 from the next cycle.
//   - Flush wins over a simultaneous push or pop.
//  Payload is written for every type and is not interpreted here.
//  Overflow and underflow are impossible by construction.
//   - A push at count == FIFO_DEPTH or a pop at count == 0 is an assertion failure.
//  Reset mid-operation discards all entries immediately, independent of clk.
// TESTING
//  1) reset=0 then release; idle -> rob_wr_valid=0, stall_out=0, count=0.
//  2) rob_wr_ready=1; push rob_id=5, data=0xDEADBEEF at edge N
//     -> cycle N+1: rob_wr_valid=1, id=5, data=0xDEADBEEF; popped at edge N+1, valid=0 after.
//  3) rob_wr_ready=0; push ids 1,2 -> stall_out=1 after the second edge.
//     Hold a third input (id 3) -> not accepted.
//     Set ready=1 -> ROB sees ids 1,2,3 in order, no duplicates.
//  4) Depth 2, count=1, push id 7 and pop in the same cycle -> count stays 1; head becomes id 7.
//     Run 10 push/pop pairs -> pointers wrap and order is preserved.
//  5) Full FIFO with valid_in=1 and flush=1 -> next cycle count=0, stall_out=0,
//     rob_wr_valid=0; the flushed input never appears.
//  6) Assert reset low between edges with count=2 -> rob_wr_valid and stall_out drop
//     to 0 at once; after release the first push is delivered correctly.
//     exception_in=1, vaddr=0x1000 -> rob_wr_exception=1, rob_wr_vaddr=0x1000.

Source files
------------

// File: rtl/wb_rob_writer.sv
// Writeback buffer between the M/WB register and the ROB completion port.
// Small in-order FIFO with a registered full-stall, cleared by ROB flush.
module wb_rob_writer #(
  parameter int WORD_SIZE       = 32,
  parameter int INSTR_TYPE_SZ   = 3,
  parameter int ROB_ENTRY_WIDTH = 5,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       valid_in,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type_in,
  input  logic [WORD_SIZE-1:0]       pc_in,
  input  logic                       exception_in,
  input  logic [WORD_SIZE-1:0]       vaddr_exception_in,
  input  logic [WORD_SIZE-1:0]       load_data_in,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id_in,
  output logic                       stall_out,
  input  logic                       rob_wr_ready,
  output logic                       rob_wr_valid,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id,
  output logic [INSTR_TYPE_SZ-1:0]   rob_wr_type,
  output logic [WORD_SIZE-1:0]       rob_wr_pc,
  output logic                       rob_wr_exception,
  output logic [WORD_SIZE-1:0]       rob_wr_vaddr,
  output logic [WORD_SIZE-1:0]       rob_wr_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ROB_ENTRY_WIDTH-1:0] id;
    logic [INSTR_TYPE_SZ-1:0]   itype;
    logic [WORD_SIZE-1:0]       pc;
    logic                       exc;
    logic [WORD_SIZE-1:0]       vaddr;
    logic [WORD_SIZE-1:0]       data;
  } ent_t;

  ent_t [FIFO_DEPTH-1:0] mem_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          stall_q, stall_d;
  logic          push, pop;
  ent_t          in_ent, head;

  assign push = valid_in && !stall_q && !flush;
  assign pop  = rob_wr_valid && rob_wr_ready && !flush;

  assign in_ent = '{id: rob_id_in, itype: instruction_type_in, pc: pc_in,
                    exc: exception_in, vaddr: vaddr_exception_in, data: load_data_in};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
    // Stall looks only at the next occupancy, so rob_wr_ready never reaches it combinationally
    stall_d = (count_d == FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      if (push) mem_q[wr_ptr_q] <= in_ent;
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign stall_out        = stall_q;
  assign rob_wr_valid     = (count_q != '0);
  assign rob_wr_id        = head.id;
  assign rob_wr_type      = head.itype;
  assign rob_wr_pc        = head.pc;
  assign rob_wr_exception = head.exc;
  assign rob_wr_vaddr     = head.vaddr;
  assign rob_wr_data      = head.data;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && count_q == FULL));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(pop && count_q == '0));
endmodule

// File: tb/tb_wb_rob_writer.sv
// Randomized bench for wb_rob_writer against a queue-based model, plus directed scenarios.
module tb_wb_rob_writer;
  localparam int WS = 32, IT = 3, RW = 5, D = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0, valid_in = 1'b0, exception_in = 1'b0, rob_wr_ready = 1'b0;
  logic [IT-1:0] instruction_type_in = '0;
  logic [WS-1:0] pc_in = '0, vaddr_exception_in = '0, load_data_in = '0;
  logic [RW-1:0] rob_id_in = '0;
  logic stall_out, rob_wr_valid, rob_wr_exception;
  logic [RW-1:0] rob_wr_id;
  logic [IT-1:0] rob_wr_type;
  logic [WS-1:0] rob_wr_pc, rob_wr_vaddr, rob_wr_data;

  wb_rob_writer #(.WORD_SIZE(WS), .INSTR_TYPE_SZ(IT), .ROB_ENTRY_WIDTH(RW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
    .instruction_type_in(instruction_type_in), .pc_in(pc_in), .exception_in(exception_in),
    .vaddr_exception_in(vaddr_exception_in), .load_data_in(load_data_in), .rob_id_in(rob_id_in),
    .stall_out(stall_out), .rob_wr_ready(rob_wr_ready), .rob_wr_valid(rob_wr_valid),
    .rob_wr_id(rob_wr_id), .rob_wr_type(rob_wr_type), .rob_wr_pc(rob_wr_pc),
    .rob_wr_exception(rob_wr_exception), .rob_wr_vaddr(rob_wr_vaddr), .rob_wr_data(rob_wr_data));

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] id; logic [IT-1:0] t; logic [WS-1:0] pc;
    logic exc; logic [WS-1:0] va; logic [WS-1:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_stall = 1'b0;
  int   delivered[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of accepted results; stall is "queue full after this edge"
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_stall = 1'b0;
    end else begin
      bit p, q;
      ent_t e;
      p = valid_in && !m_stall && !flush;
      q = (mq.size() != 0) && rob_wr_ready && !flush;
      e = '{id: rob_id_in, t: instruction_type_in, pc: pc_in, exc: exception_in,
            va: vaddr_exception_in, data: load_data_in};
      if (flush) mq.delete();
      else begin
        if (q) void'(mq.pop_front());
        if (p) mq.push_back(e);
      end
      m_stall = (mq.size() == D);
    end
  end

  always @(posedge clk)
    if (reset && rob_wr_valid && rob_wr_ready && !flush) delivered.push_back(int'(rob_wr_id));

  always @(negedge clk) begin
    chk("valid", 64'(rob_wr_valid), 64'(mq.size() != 0));
    chk("stall", 64'(stall_out), 64'(m_stall));
    if (reset && mq.size() != 0) begin
      chk("head_id", 64'(rob_wr_id), 64'(mq[0].id));
      chk("head_type", 64'(rob_wr_type), 64'(mq[0].t));
      chk("head_pc", 64'(rob_wr_pc), 64'(mq[0].pc));
      chk("head_exc", 64'(rob_wr_exception), 64'(mq[0].exc));
      chk("head_vaddr", 64'(rob_wr_vaddr), 64'(mq[0].va));
      chk("head_data", 64'(rob_wr_data), 64'(mq[0].data));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int id, input logic [WS-1:0] data);
    valid_in = 1'b1; rob_id_in = RW'(id); load_data_in = data;
    pc_in = 32'h400 + WS'(id * 4); instruction_type_in = IT'(id);
    exception_in = 1'b0; vaddr_exception_in = '0;
  endtask

  initial begin
    bool_acc: begin end
    #1 reset = 1'b0;
    repeat (3) cyc();
    // Reset state
    chk("rst_valid", 64'(rob_wr_valid), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    chk("rst_data", 64'(rob_wr_data), 64'd0);
    chk("rst_id", 64'(rob_wr_id), 64'd0);
    reset = 1'b1;
    cyc();

    // Single push, delivered next cycle, popped the cycle after
    rob_wr_ready = 1'b1;
    drive(5, 32'hDEADBEEF);
    cyc();
    valid_in = 1'b0;
    chk("t2_valid", 64'(rob_wr_valid), 64'd1);
    chk("t2_id", 64'(rob_wr_id), 64'd5);
    chk("t2_data", 64'(rob_wr_data), 64'hDEADBEEF);
    cyc();
    chk("t2_valid_after", 64'(rob_wr_valid), 64'd0);

    // Fill, stall, held input accepted later, in order
    delivered.delete();
    rob_wr_ready = 1'b0;
    drive(1, 32'h11); cyc();
    drive(2, 32'h22); cyc();
    chk("t3_stall", 64'(stall_out), 64'd1);
    drive(3, 32'h33); cyc(); cyc();
    chk("t3_stall_hold", 64'(stall_out), 64'd1);
    chk("t3_head", 64'(rob_wr_id), 64'd1);
    rob_wr_ready = 1'b1;
    begin
      bit acc, done;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
        acc = !stall_out;
        cyc();
        if (acc) done = 1'b1;
      end
      if (!done) chk("t3_accept_timeout", 64'd0, 64'd1);
    end
    valid_in = 1'b0;
    repeat (5) cyc();
    chk("t3_cnt", 64'(delivered.size()), 64'd3);
    if (delivered.size() == 3) begin
      chk("t3_ord0", 64'(delivered[0]), 64'd1);
      chk("t3_ord1", 64'(delivered[1]), 64'd2);
      chk("t3_ord2", 64'(delivered[2]), 64'd3);
    end

    // Simultaneous push/pop at count 1, then wrap pointers
    rob_wr_ready = 1'b0;
    drive(6, 32'h66); cyc();
    rob_wr_ready = 1'b1;
    drive(7, 32'h77); cyc();
    chk("t4_valid", 64'(rob_wr_valid), 64'd1);
    chk("t4_head", 64'(rob_wr_id), 64'd7);
    chk("t4_stall", 64'(stall_out), 64'd0);
    for (int i = 8; i < 18; i++) begin
      drive(i, 32'(i) << 4); cyc();
      chk("t4_wrap_head", 64'(rob_wr_id), 64'(i));
      chk("t4_wrap_data", 64'(rob_wr_data), 64'(i) << 4);
    end
    valid_in = 1'b0; cyc();
    chk("t4_drained", 64'(rob_wr_valid), 64'd0);

    // Flush while full with a live input
    rob_wr_ready = 1'b0;
    drive(20, 32'h20); cyc();
    drive(21, 32'h21); cyc();
    drive(22, 32'h22); flush = 1'b1; cyc();
    flush = 1'b0; valid_in = 1'b0;
    chk("t5_valid", 64'(rob_wr_valid), 64'd0);
    chk("t5_stall", 64'(stall_out), 64'd0);
    delivered.delete();
    rob_wr_ready = 1'b1;
    repeat (3) cyc();
    chk("t5_none", 64'(delivered.size()), 64'd0);

    // Asynchronous reset between edges at count 2
    rob_wr_ready = 1'b0;
    drive(30, 32'h30); cyc();
    drive(31, 32'h31); cyc();
    valid_in = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0; #1;
    chk("t6_valid", 64'(rob_wr_valid), 64'd0);
    chk("t6_stall", 64'(stall_out), 64'd0);
    chk("t6_data", 64'(rob_wr_data), 64'd0);
    cyc(); reset = 1'b1; cyc();
    drive(9, 32'h99); exception_in = 1'b1; vaddr_exception_in = 32'h1000; cyc();
    valid_in = 1'b0; exception_in = 1'b0;
    chk("t6_id", 64'(rob_wr_id), 64'd9);
    chk("t6_exc", 64'(rob_wr_exception), 64'd1);
    chk("t6_vaddr", 64'(rob_wr_vaddr), 64'h1000);
    rob_wr_ready = 1'b1; cyc();

    // Random traffic; M/WB holds its payload while stalled
    for (int n = 0; n < 400; n++) begin
      if (!(valid_in && stall_out)) begin
        valid_in = ($urandom % 4) != 0;
        rob_id_in = RW'($urandom);
        instruction_type_in = IT'($urandom);
        pc_in = $urandom; exception_in = $urandom % 2;
        vaddr_exception_in = $urandom; load_data_in = $urandom;
      end
      rob_wr_ready = ($urandom % 3) != 0;
      flush = ($urandom % 16) == 0;
      cyc();
    end
    flush = 1'b0; valid_in = 1'b0; rob_wr_ready = 1'b1;
    repeat (4) cyc();
    chk("final_empty", 64'(rob_wr_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
